sl_host_fifo_bridge: RTL
========================

// Module: sl_host_fifo_bridge
// PURPOSE
//  Host-side end of the 34-bit modifier-word FIFO protocol ({mod[1:0], payload[31:0]}; mod 0=CONFIG,
//  1=DATA, 2=STATUS, 3=CHANNEL). An APB slave turns register writes into command words for the command
//  FIFO. It pops report words from the report FIFO and decodes them into readable shadow registers.
//  Sits between the system APB and the pair of CDC FIFOs in front of the SL transceiver core.
// PARAMETERS
//  ADDR_W       6   APB address width (byte address; paddr[5:2] selects register)
//  CFG_W        16  config field width (TX and RX)
//  RX_STAT_W    16  RX status field width
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous, active-low reset
//  psel,penable   in   1,1    APB select / enable
//  pwrite         in   1      APB direction
//  paddr          in   ADDR_W APB address
//  pwdata         in   32     APB write data
//  prdata         out  32     APB read data, valid while pready=1
//  pready         out  1      APB ready
//  pslverr        out  1      APB error, valid while pready=1
//  cmd_fifo_full  in   1      command FIFO full
//  cmd_fifo_data  out  34     command word
//  cmd_fifo_inc   out  1      command push strobe, 1 cycle
//  rep_fifo_empty in   1      report FIFO empty
//  rep_fifo_data  in   34     report word; show-ahead, valid while !empty
//  rep_fifo_inc   out  1      report pop strobe, 1 cycle
//  irq            out  1      interrupt, level (only with SL_HOST_IRQ_EN)
// BEHAVIOUR
//  Reset: prdata=0, pready=0, pslverr=0, cmd_fifo_data=0, cmd_fifo_inc=0, rep_fifo_inc=0, irq=0.
//   All shadows and sticky flags reset to 0.
//  Register map (byte offset):
//   0x00 CHANNEL  W: push {3,31'b0,pwdata[0]}.         R: rep_channel
//   0x04 CONFIG   W: push {0,0..,pwdata[CFG_W-1:0]}.    R: 0
//   0x08 TXDATA   W: push {1,pwdata}.                   R: 0
//   0x0C TX_CFG R, 0x10 TX_STAT R (bit0 busy), 0x14 RX_CFG R, 0x18 RX_STAT R
//   0x1C RX_DATA  R: returns rx_data and clears rx_valid
//   0x20 HOST_STAT R: [0]rx_valid [1]rx_overrun [2]proto_err [3]cmd_fifo_full [4]rep_fifo_empty
//     [5]rep_channel. W: write-1-to-clear bits [2:1].
//  APB FSM A_IDLE/A_RESP:
//   - A_IDLE with psel&penable → A_RESP. Exception: push write while cmd_fifo_full stays in A_IDLE.
//   - A_RESP: pready=1 for exactly 1 cycle, then → A_IDLE. Min 1 wait state per access.
//   - Push data is registered into cmd_fifo_data on the A_IDLE→A_RESP edge. cmd_fifo_inc=1 during A_RESP.
//   - pslverr=1 for: unmapped offset, write to a read-only register, read of CHANNEL/CONFIG/TXDATA.
//     An error access has no push and no side effects.
//  Report FSM R_IDLE/R_POP (one word per 2 cycles):
//   - R_IDLE & !rep_fifo_empty: decode the word, update shadows, → R_POP.
//   - R_POP: rep_fifo_inc=1, → R_IDLE.
//   - Decode CHANNEL: rep_channel <= data[0].
//   - Decode CONFIG: rep_channel ? rx_cfg : tx_cfg <= data[CFG_W-1:0].
//   - Decode STATUS: rep_channel ? rx_stat <= data[RX_STAT_W-1:0] : tx_stat <= data[0].
//   - Decode DATA with rep_channel=1: rx_data <= data, rx_valid <= 1. If rx_valid was already 1
//     and is not being cleared this cycle: rx_overrun <= 1.
//   - Decode DATA with rep_channel=0: word discarded, proto_err <= 1.
//  Simultaneous events:
//   - RX_DATA read in A_RESP on the same cycle as a DATA decode: the new word wins. rx_valid stays 1,
//     no overrun, and prdata returns the old value.
//   - W1C on the same cycle as a set: the set wins.
//  Reset mid-access: both FSMs return to idle, with no partial push or pop.
// CONFIGURATION
//  SL_HOST_IRQ_EN defined:
//   - Adds register 0x24 IRQ_EN, R/W, bits [2:0] = {proto_err, rx_overrun, rx_valid}.
//   - Adds port irq, registered: irq = |(IRQ_EN & flags).
//  SL_HOST_IRQ_EN undefined: no irq port, and 0x24 is unmapped (pslverr).
// STRUCTURE
//  Package sl_fifo_pkg holds:
//   - modifier constants CONFIG/DATA/STATUS/CHANNEL_MOD, and FIFO_W=34, HMB=33, LMB=32
//   - register offset localparams and HOST_STAT bit indices
//  Sub-module sl_report_decoder holds the report FSM, the shadows and the sticky flags.
//  The top level holds the APB FSM and the read mux.
// TESTING
//  1. Write 0x08=0xDEADBEEF, FIFO not full:
//     → 1 wait state, then cmd_fifo_data=34'h1_DEADBEEF and cmd_fifo_inc pulses 1 cycle.
//  2. Write 0x04=0x1234 with cmd_fifo_full=1 for 5 cycles:
//     → pready low for 5 cycles, then one push of 34'h0_00001234 and no duplicate.
//  3. Report stream CHAN(1), CONF(0xA5), DATA(0x55AA00FF):
//     → RX_CFG reads 0xA5 and RX_DATA reads 0x55AA00FF. HOST_STAT[0] goes 1→0 after the read.
//     → rep_fifo_inc pulses 3 times.
//  4. Two DATA words with no read in between → HOST_STAT[1]=1. Write 0x20=0x2 → bit clears.
//  5. CHAN(0) then DATA → proto_err=1 and rx_data unchanged.
//     With SL_HOST_IRQ_EN and IRQ_EN=0x4 → irq=1.
//  6. Read 0x3C → pslverr=1. Write 0x0C → pslverr=1 and no cmd_fifo_inc.
//     Assert rst_n mid-wait → pready=0 and no push.

Source files
------------

// File: rtl/sl_fifo_pkg.sv
// Shared constants for the 34-bit modifier-word FIFO protocol: modifiers, register offsets, HOST_STAT bits.
package sl_fifo_pkg;
  localparam int FIFO_W = 34;
  localparam int HMB    = 33;
  localparam int LMB    = 32;

  localparam logic [1:0] CONFIG_MOD  = 2'd0;
  localparam logic [1:0] DATA_MOD    = 2'd1;
  localparam logic [1:0] STATUS_MOD  = 2'd2;
  localparam logic [1:0] CHANNEL_MOD = 2'd3;

  // Register word index, i.e. paddr[5:2]
  localparam logic [3:0] REG_CHANNEL   = 4'd0;
  localparam logic [3:0] REG_CONFIG    = 4'd1;
  localparam logic [3:0] REG_TXDATA    = 4'd2;
  localparam logic [3:0] REG_TX_CFG    = 4'd3;
  localparam logic [3:0] REG_TX_STAT   = 4'd4;
  localparam logic [3:0] REG_RX_CFG    = 4'd5;
  localparam logic [3:0] REG_RX_STAT   = 4'd6;
  localparam logic [3:0] REG_RX_DATA   = 4'd7;
  localparam logic [3:0] REG_HOST_STAT = 4'd8;
  localparam logic [3:0] REG_IRQ_EN    = 4'd9;

  localparam int HS_RX_VALID   = 0;
  localparam int HS_RX_OVERRUN = 1;
  localparam int HS_PROTO_ERR  = 2;
  localparam int HS_CMD_FULL   = 3;
  localparam int HS_REP_EMPTY  = 4;
  localparam int HS_REP_CHAN   = 5;

  typedef enum logic {A_IDLE, A_RESP} apb_state_e;
  typedef enum logic {R_IDLE, R_POP}  rep_state_e;
endpackage

// File: rtl/sl_report_decoder.sv
// Report FIFO consumer: pops one word every two cycles and decodes it into shadows and sticky flags.
module sl_report_decoder
  import sl_fifo_pkg::*;
#(
  parameter int CFG_W     = 16,
  parameter int RX_STAT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rep_fifo_empty_i,
  input  logic [FIFO_W-1:0]    rep_fifo_data_i,
  output logic                 rep_fifo_inc_o,
  input  logic                 clr_rx_valid_i,
  input  logic [1:0]           w1c_i,
  output logic                 rep_channel_o,
  output logic [CFG_W-1:0]     tx_cfg_o,
  output logic [CFG_W-1:0]     rx_cfg_o,
  output logic                 tx_stat_o,
  output logic [RX_STAT_W-1:0] rx_stat_o,
  output logic [31:0]          rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_overrun_o,
  output logic                 proto_err_o
);
  rep_state_e           state_q;
  logic                 inc_q;
  logic                 chan_q;
  logic [CFG_W-1:0]     tx_cfg_q, rx_cfg_q;
  logic                 tx_stat_q;
  logic [RX_STAT_W-1:0] rx_stat_q;
  logic [31:0]          rx_data_q;
  logic                 rx_valid_q, overrun_q, perr_q;
  logic [1:0]           mod;
  logic [31:0]          payload;

  assign mod     = rep_fifo_data_i[HMB:LMB];
  assign payload = rep_fifo_data_i[LMB-1:0];

  // Clears come first so a decode later in the block overrides them (set wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= R_IDLE;
      inc_q      <= 1'b0;
      chan_q     <= 1'b0;
      tx_cfg_q   <= '0;
      rx_cfg_q   <= '0;
      tx_stat_q  <= 1'b0;
      rx_stat_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      if (clr_rx_valid_i) rx_valid_q <= 1'b0;
      if (w1c_i[0])       overrun_q  <= 1'b0;
      if (w1c_i[1])       perr_q     <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (!rep_fifo_empty_i) begin
            state_q <= R_POP;
            inc_q   <= 1'b1;
            case (mod)
              CHANNEL_MOD: chan_q <= payload[0];
              CONFIG_MOD: begin
                if (chan_q) rx_cfg_q <= payload[CFG_W-1:0];
                else        tx_cfg_q <= payload[CFG_W-1:0];
              end
              STATUS_MOD: begin
                if (chan_q) rx_stat_q <= payload[RX_STAT_W-1:0];
                else        tx_stat_q <= payload[0];
              end
              default: begin
                if (chan_q) begin
                  rx_data_q  <= payload;
                  rx_valid_q <= 1'b1;
                  if (rx_valid_q && !clr_rx_valid_i) overrun_q <= 1'b1;
                end else begin
                  perr_q <= 1'b1;
                end
              end
            endcase
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign rep_fifo_inc_o = inc_q;
  assign rep_channel_o  = chan_q;
  assign tx_cfg_o       = tx_cfg_q;
  assign rx_cfg_o       = rx_cfg_q;
  assign tx_stat_o      = tx_stat_q;
  assign rx_stat_o      = rx_stat_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overrun_o   = overrun_q;
  assign proto_err_o    = perr_q;
endmodule

// File: rtl/sl_host_fifo_bridge.sv
// APB slave bridging register accesses to the command FIFO and report shadows to APB reads.
// Optional SL_HOST_IRQ_EN adds the IRQ_EN register at 0x24 and the level irq output.
module sl_host_fifo_bridge
  import sl_fifo_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int CFG_W     = 16,
  parameter int RX_STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              cmd_fifo_full,
  output logic [FIFO_W-1:0] cmd_fifo_data,
  output logic              cmd_fifo_inc,
  input  logic              rep_fifo_empty,
  input  logic [FIFO_W-1:0] rep_fifo_data,
  output logic              rep_fifo_inc
`ifdef SL_HOST_IRQ_EN
  ,
  output logic              irq
`endif
);
  apb_state_e          state_q;
  logic [31:0]         prdata_q;
  logic                pready_q, pslverr_q;
  logic [FIFO_W-1:0]   cmd_data_q;
  logic                cmd_inc_q;
  logic                clr_rxv_q;
  logic [1:0]          w1c_q;

  logic                 rep_channel, tx_stat, rx_valid, rx_overrun, proto_err;
  logic [CFG_W-1:0]     tx_cfg, rx_cfg;
  logic [RX_STAT_W-1:0] rx_stat;
  logic [31:0]          rx_data;

  logic [3:0]          idx;
  logic                acc_err, push_reg;
  logic [FIFO_W-1:0]   push_word;
  logic [31:0]         rd_val;

`ifdef SL_HOST_IRQ_EN
  logic [2:0] irq_en_q;
  logic       irq_q;
`endif

  assign idx = paddr[5:2];

  always_comb begin
    acc_err   = 1'b0;
    push_reg  = 1'b0;
    push_word = '0;
    rd_val    = '0;
    case (idx)
      REG_CHANNEL: begin
        push_reg  = 1'b1;
        acc_err   = !pwrite;
        push_word = {CHANNEL_MOD, 31'b0, pwdata[0]};
      end
      REG_CONFIG: begin
        push_reg  = 1'b1;
        acc_err   = !pwrite;
        push_word = {CONFIG_MOD, {(32-CFG_W){1'b0}}, pwdata[CFG_W-1:0]};
      end
      REG_TXDATA: begin
        push_reg  = 1'b1;
        acc_err   = !pwrite;
        push_word = {DATA_MOD, pwdata};
      end
      REG_TX_CFG:  begin acc_err = pwrite; rd_val = {{(32-CFG_W){1'b0}}, tx_cfg}; end
      REG_TX_STAT: begin acc_err = pwrite; rd_val = {31'b0, tx_stat}; end
      REG_RX_CFG:  begin acc_err = pwrite; rd_val = {{(32-CFG_W){1'b0}}, rx_cfg}; end
      REG_RX_STAT: begin acc_err = pwrite; rd_val = {{(32-RX_STAT_W){1'b0}}, rx_stat}; end
      REG_RX_DATA: begin acc_err = pwrite; rd_val = rx_data; end
      REG_HOST_STAT: begin
        rd_val[HS_RX_VALID]   = rx_valid;
        rd_val[HS_RX_OVERRUN] = rx_overrun;
        rd_val[HS_PROTO_ERR]  = proto_err;
        rd_val[HS_CMD_FULL]   = cmd_fifo_full;
        rd_val[HS_REP_EMPTY]  = rep_fifo_empty;
        rd_val[HS_REP_CHAN]   = rep_channel;
      end
`ifdef SL_HOST_IRQ_EN
      REG_IRQ_EN: rd_val = {29'b0, irq_en_q};
`endif
      default: acc_err = 1'b1;
    endcase
    // Misaligned byte offsets do not hit any register
    if (paddr[1:0] != 2'b00) acc_err = 1'b1;
  end

  // A push write against a full FIFO simply holds in A_IDLE, inserting wait states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= A_IDLE;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      cmd_data_q <= '0;
      cmd_inc_q  <= 1'b0;
      clr_rxv_q  <= 1'b0;
      w1c_q      <= 2'b00;
`ifdef SL_HOST_IRQ_EN
      irq_en_q   <= 3'b000;
`endif
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cmd_inc_q <= 1'b0;
      clr_rxv_q <= 1'b0;
      w1c_q     <= 2'b00;
      case (state_q)
        A_IDLE: begin
          if (psel && penable &&
              !(pwrite && push_reg && !acc_err && cmd_fifo_full)) begin
            state_q   <= A_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= acc_err;
            prdata_q  <= (!pwrite && !acc_err) ? rd_val : 32'h0;
            if (!acc_err) begin
              if (pwrite && push_reg) begin
                cmd_data_q <= push_word;
                cmd_inc_q  <= 1'b1;
              end
              if (!pwrite && idx == REG_RX_DATA) clr_rxv_q <= 1'b1;
              if (pwrite && idx == REG_HOST_STAT)
                w1c_q <= pwdata[HS_PROTO_ERR:HS_RX_OVERRUN];
`ifdef SL_HOST_IRQ_EN
              if (pwrite && idx == REG_IRQ_EN) irq_en_q <= pwdata[2:0];
`endif
            end
          end
        end
        default: state_q <= A_IDLE;
      endcase
    end
  end

`ifdef SL_HOST_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |(irq_en_q & {proto_err, rx_overrun, rx_valid});
  end
  assign irq = irq_q;
`endif

  sl_report_decoder #(
    .CFG_W     (CFG_W),
    .RX_STAT_W (RX_STAT_W)
  ) u_dec (
    .clk              (clk),
    .rst_n            (rst_n),
    .rep_fifo_empty_i (rep_fifo_empty),
    .rep_fifo_data_i  (rep_fifo_data),
    .rep_fifo_inc_o   (rep_fifo_inc),
    .clr_rx_valid_i   (clr_rxv_q),
    .w1c_i            (w1c_q),
    .rep_channel_o    (rep_channel),
    .tx_cfg_o         (tx_cfg),
    .rx_cfg_o         (rx_cfg),
    .tx_stat_o        (tx_stat),
    .rx_stat_o        (rx_stat),
    .rx_data_o        (rx_data),
    .rx_valid_o       (rx_valid),
    .rx_overrun_o     (rx_overrun),
    .proto_err_o      (proto_err)
  );

  assign prdata        = prdata_q;
  assign pready        = pready_q;
  assign pslverr       = pslverr_q;
  assign cmd_fifo_data = cmd_data_q;
  assign cmd_fifo_inc  = cmd_inc_q;
endmodule
